// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch buffer: field widths, the
// "no exception" code, the PC increment between slots, and the entry record.
package fetch_pkg;

    localparam int INST_W       = 32;
    localparam int PC_W         = 32;
    localparam int EXC_W        = 7;
    localparam int COOKIE_W_DEF = 32;

    localparam logic [EXC_W-1:0] EXC_NONE = 7'd0;
    localparam logic [PC_W-1:0]  PC_STEP  = 32'd4;

    // One queued instruction as seen by decode (default-width cookie view).
    typedef struct packed {
        logic [INST_W-1:0]       inst;
        logic [PC_W-1:0]         pc;
        logic [COOKIE_W_DEF-1:0] cookie;
        logic [EXC_W-1:0]        exception;
    } fetch_entry_t;

    // Number of instructions a fetch packet contributes to the queue.
    // A faulting packet yields one marker entry, an aligned packet yields two
    // slots, and a packet starting at the upper slot yields only that slot.
    function automatic logic [1:0] packet_slots(input logic [EXC_W-1:0] exc,
                                                input logic              pc_bit2);
        if (exc != EXC_NONE) begin
            return 2'd1;
        end else if (!pc_bit2) begin
            return 2'd2;
        end else begin
            return 2'd1;
        end
    endfunction

endpackage

// File: rtl/fetch_buf_mem.sv
// Entry storage for the instruction fetch buffer: a register array with two
// write ports (consecutive slots of one packet) and one asynchronous read port
// for the queue head. Pointer and occupancy control live in the parent.
module fetch_buf_mem
    import fetch_pkg::*;
#(
    parameter int DEPTH        = 8,
    parameter int COOKIE_WIDTH = 32
) (
    input  logic                     clk,
    input  logic                     we0,
    input  logic [$clog2(DEPTH)-1:0] waddr0,
    input  logic [INST_W-1:0]        winst0,
    input  logic [PC_W-1:0]          wpc0,
    input  logic [COOKIE_WIDTH-1:0]  wcookie0,
    input  logic [EXC_W-1:0]         wexc0,
    input  logic                     we1,
    input  logic [$clog2(DEPTH)-1:0] waddr1,
    input  logic [INST_W-1:0]        winst1,
    input  logic [PC_W-1:0]          wpc1,
    input  logic [COOKIE_WIDTH-1:0]  wcookie1,
    input  logic [EXC_W-1:0]         wexc1,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [INST_W-1:0]        rinst,
    output logic [PC_W-1:0]          rpc,
    output logic [COOKIE_WIDTH-1:0]  rcookie,
    output logic [EXC_W-1:0]         rexc
);

    logic [INST_W-1:0]       inst_mem   [DEPTH];
    logic [PC_W-1:0]         pc_mem     [DEPTH];
    logic [COOKIE_WIDTH-1:0] cookie_mem [DEPTH];
    logic [EXC_W-1:0]        exc_mem    [DEPTH];

    // Write up to two consecutive entries; the parent guarantees distinct addresses.
    always_ff @(posedge clk) begin
        if (we0) begin
            inst_mem[waddr0]   <= winst0;
            pc_mem[waddr0]     <= wpc0;
            cookie_mem[waddr0] <= wcookie0;
            exc_mem[waddr0]    <= wexc0;
        end
        if (we1) begin
            inst_mem[waddr1]   <= winst1;
            pc_mem[waddr1]     <= wpc1;
            cookie_mem[waddr1] <= wcookie1;
            exc_mem[waddr1]    <= wexc1;
        end
    end

    // Head entry is read without a register so decode sees it the cycle after the write.
    always_comb begin
        rinst   = inst_mem[raddr];
        rpc     = pc_mem[raddr];
        rcookie = cookie_mem[raddr];
        rexc    = exc_mem[raddr];
    end

endmodule

// File: rtl/inst_fetch_buf.sv
// Instruction fetch buffer between the instruction cache and decode.
// Splits 64-bit two-slot fetch packets into 32-bit instructions, queues them
// in order, and hands one per cycle to decode under a valid/ready handshake.
// in_ready asks for two free entries so a full packet always fits.
// Optional build macro INST_FETCH_BUF_BYPASS_EN: when the queue is empty the
// first entry of an accepted packet is also presented on out_* in the same
// cycle (zero-latency path). Without it there is no in_* -> out_* path.
module inst_fetch_buf
    import fetch_pkg::*;
#(
    parameter int DEPTH        = 8,
    parameter int COOKIE_WIDTH = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    flush,
    input  logic                    in_valid,
    input  logic [63:0]             in_data,
    input  logic [31:0]             in_pc,
    input  logic [COOKIE_WIDTH-1:0] in_cookie,
    input  logic [6:0]              in_exception,
    output logic                    in_ready,
    output logic                    out_valid,
    output logic [31:0]             out_inst,
    output logic [31:0]             out_pc,
    output logic [COOKIE_WIDTH-1:0] out_cookie,
    output logic [6:0]              out_exception,
    input  logic                    out_ready
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] PKT_MAX   = CNT_W'(2);

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;

    logic [CNT_W-1:0] free_cnt;
    logic             push_acc;
    logic             pop;
    logic [1:0]       slots;
    logic [1:0]       n_push;

    // First and second entries carved out of the incoming packet.
    logic [INST_W-1:0]       e0_inst;
    logic [PC_W-1:0]         e0_pc;
    logic [EXC_W-1:0]        e0_exc;
    logic [INST_W-1:0]       e1_inst;
    logic [PC_W-1:0]         e1_pc;
    logic                    we0;
    logic                    we1;

    // Head entry as stored in the array.
    logic [INST_W-1:0]       head_inst;
    logic [PC_W-1:0]         head_pc;
    logic [COOKIE_WIDTH-1:0] head_cookie;
    logic [EXC_W-1:0]        head_exc;

    // Occupancy view and handshake qualifiers; ready looks only at registered count.
    always_comb begin
        free_cnt = DEPTH_CNT - count;
        in_ready = (free_cnt >= PKT_MAX);
        push_acc = in_valid && in_ready && !flush;
        slots    = packet_slots(in_exception, in_pc[2]);
        n_push   = push_acc ? slots : 2'd0;
        we0      = push_acc;
        we1      = push_acc && (slots == 2'd2);
    end

    // Split the packet: a fault produces a zero-instruction marker, the upper
    // slot is used alone when the PC already points at it.
    always_comb begin
        e0_inst = in_data[31:0];
        e0_pc   = in_pc;
        e0_exc  = EXC_NONE;
        if (in_exception != EXC_NONE) begin
            e0_inst = '0;
            e0_exc  = in_exception;
        end else if (in_pc[2]) begin
            e0_inst = in_data[63:32];
        end
        e1_inst = in_data[63:32];
        e1_pc   = in_pc + PC_STEP;
    end

    fetch_buf_mem #(
        .DEPTH        (DEPTH),
        .COOKIE_WIDTH (COOKIE_WIDTH)
    ) u_mem (
        .clk      (clk),
        .we0      (we0),
        .waddr0   (wr_ptr),
        .winst0   (e0_inst),
        .wpc0     (e0_pc),
        .wcookie0 (in_cookie),
        .wexc0    (e0_exc),
        .we1      (we1),
        .waddr1   (wr_ptr + PTR_W'(1)),
        .winst1   (e1_inst),
        .wpc1     (e1_pc),
        .wcookie1 (in_cookie),
        .wexc1    (EXC_NONE),
        .raddr    (rd_ptr),
        .rinst    (head_inst),
        .rpc      (head_pc),
        .rcookie  (head_cookie),
        .rexc     (head_exc)
    );

`ifdef INST_FETCH_BUF_BYPASS_EN
    logic bypass;

    // Empty queue with an accepted packet: show its first entry immediately.
    // The entry is still written at rd_ptr, so a same-cycle pop simply
    // advances rd_ptr past it and the ordinary count update stays correct.
    always_comb begin
        bypass        = (count == '0) && push_acc;
        out_valid     = (count != '0) || bypass;
        out_inst      = bypass ? e0_inst   : head_inst;
        out_pc        = bypass ? e0_pc     : head_pc;
        out_cookie    = bypass ? in_cookie : head_cookie;
        out_exception = bypass ? e0_exc    : head_exc;
        pop           = out_valid && out_ready && !flush;
    end
`else
    // Head presentation straight from the array; one cycle minimum latency.
    always_comb begin
        out_valid     = (count != '0);
        out_inst      = head_inst;
        out_pc        = head_pc;
        out_cookie    = head_cookie;
        out_exception = head_exc;
        pop           = out_valid && out_ready && !flush;
    end
`endif

    // Pointer/count update: reset beats flush, flush beats push and pop.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            wr_ptr <= wr_ptr + PTR_W'(n_push);
            rd_ptr <= rd_ptr + PTR_W'(pop);
            count  <= count + CNT_W'(n_push) - CNT_W'(pop);
        end
    end

endmodule

// File: tb/tb_inst_fetch_buf.sv
// Bench for inst_fetch_buf (default build, DEPTH=8, COOKIE_WIDTH=32).
// A queue-based reference model tracks expected contents; one process
// compares every cycle, and the stimulus adds hand-computed expectations.
module tb_inst_fetch_buf;
    import fetch_pkg::*;

    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic [63:0] in_data;
    logic [31:0] in_pc;
    logic [31:0] in_cookie;
    logic [6:0]  in_exception;
    logic        in_ready;
    logic        out_valid;
    logic [31:0] out_inst;
    logic [31:0] out_pc;
    logic [31:0] out_cookie;
    logic [6:0]  out_exception;
    logic        out_ready;

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;

    fetch_entry_t q[$];

    always #5 clk = ~clk;

    inst_fetch_buf #(.DEPTH(DEPTH), .COOKIE_WIDTH(32)) dut (
        .clk           (clk),
        .rst           (rst),
        .flush         (flush),
        .in_valid      (in_valid),
        .in_data       (in_data),
        .in_pc         (in_pc),
        .in_cookie     (in_cookie),
        .in_exception  (in_exception),
        .in_ready      (in_ready),
        .out_valid     (out_valid),
        .out_inst      (out_inst),
        .out_pc        (out_pc),
        .out_cookie    (out_cookie),
        .out_exception (out_exception),
        .out_ready     (out_ready)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    // Reference model: an in-order list of instructions.
    always @(posedge clk) begin
        bit           rdy;
        fetch_entry_t e;
        rdy = ((DEPTH - q.size()) >= 2);
        if (rst || flush) begin
            q.delete();
        end else begin
            if (q.size() != 0 && out_ready) void'(q.pop_front());
            if (in_valid && rdy) begin
                e.cookie = in_cookie;
                e.pc     = in_pc;
                if (in_exception != 7'd0) begin
                    e.inst      = 32'd0;
                    e.exception = in_exception;
                    q.push_back(e);
                end else if (in_pc[2] == 1'b0) begin
                    e.inst      = in_data[31:0];
                    e.exception = 7'd0;
                    q.push_back(e);
                    e.inst = in_data[63:32];
                    e.pc   = in_pc + 32'd4;
                    q.push_back(e);
                end else begin
                    e.inst      = in_data[63:32];
                    e.exception = 7'd0;
                    q.push_back(e);
                end
            end
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("m_in_ready", 64'(in_ready), 64'((DEPTH - q.size()) >= 2));
            chk("m_out_valid", 64'(out_valid), 64'(q.size() != 0));
            if (q.size() != 0 && out_valid) begin
                chk("m_inst", 64'(out_inst), 64'(q[0].inst));
                chk("m_pc", 64'(out_pc), 64'(q[0].pc));
                chk("m_cookie", 64'(out_cookie), 64'(q[0].cookie));
                chk("m_exc", 64'(out_exception), 64'(q[0].exception));
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [31:0] pc, input logic [63:0] data, input logic [6:0] exc);
        in_valid     = 1'b1;
        in_pc        = pc;
        in_data      = data;
        in_cookie    = pc ^ 32'h5A5A0000;
        in_exception = exc;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got running required finished");
        $fatal(1, "timeout");
    end

    initial begin
        int pops;
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0; in_pc = '0;
        in_cookie = '0; in_exception = '0; out_ready = 1'b1;
        cyc(); cyc();
        rst = 1'b0;
        chk_en = 1'b1;
        @(negedge clk);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);

        // Aligned packet: two instructions in order.
        cyc();
        send(32'h1C000000, 64'h22222222_11111111, 7'd0);
        cyc();
        in_valid = 1'b0;
        @(negedge clk);
        chk("al0_inst", 64'(out_inst), 64'h11111111);
        chk("al0_pc", 64'(out_pc), 64'h1C000000);
        cyc();
        @(negedge clk);
        chk("al1_inst", 64'(out_inst), 64'h22222222);
        chk("al1_pc", 64'(out_pc), 64'h1C000004);
        cyc();
        @(negedge clk);
        chk("al_empty", 64'(out_valid), 64'd0);

        // Unaligned packet: upper slot only.
        cyc();
        send(32'h1C000014, 64'hBBBBBBBB_AAAAAAAA, 7'd0);
        cyc();
        in_valid = 1'b0;
        @(negedge clk);
        chk("ua_inst", 64'(out_inst), 64'hBBBBBBBB);
        chk("ua_pc", 64'(out_pc), 64'h1C000014);
        cyc();
        @(negedge clk);
        chk("ua_empty", 64'(out_valid), 64'd0);

        // Exception packet: single marker entry despite PC[2]=0.
        cyc();
        send(32'h1C000020, 64'h12345678_9ABCDEF0, 7'h08);
        cyc();
        in_valid = 1'b0;
        in_exception = 7'd0;
        @(negedge clk);
        chk("ex_inst", 64'(out_inst), 64'h0);
        chk("ex_pc", 64'(out_pc), 64'h1C000020);
        chk("ex_code", 64'(out_exception), 64'h08);
        cyc();
        @(negedge clk);
        chk("ex_empty", 64'(out_valid), 64'd0);

        // Backpressure: fill to 8 (write pointer wraps), hold a fifth packet.
        cyc();
        out_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            send(32'h1C000100 + 32'(8 * k),
                 {32'hA0000000 + 32'(2 * k + 1), 32'hA0000000 + 32'(2 * k)}, 7'd0);
            cyc();
        end
        send(32'h1C000120, 64'hA0000009_A0000008, 7'd0);
        @(negedge clk);
        chk("bp_full_ready", 64'(in_ready), 64'd0);
        chk("bp_full_head", 64'(out_pc), 64'h1C000100);
        cyc();
        @(negedge clk);
        chk("bp_held_ready", 64'(in_ready), 64'd0);
        out_ready = 1'b1;
        @(negedge clk);
        chk("bp_pop1_ready", 64'(in_ready), 64'd0);
        chk("bp_pop1_pc", 64'(out_pc), 64'h1C000104);
        chk("bp_pop1_inst", 64'(out_inst), 64'hA0000001);
        @(negedge clk);
        chk("bp_pop2_ready", 64'(in_ready), 64'd1);
        chk("bp_pop2_pc", 64'(out_pc), 64'h1C000108);
        cyc();
        in_valid = 1'b0;
        @(negedge clk);
        // Push of 2 and pop of 1 at count 6 leaves 7: no room for a packet.
        chk("pp_count7_ready", 64'(in_ready), 64'd0);
        chk("pp_head_pc", 64'(out_pc), 64'h1C00010C);
        pops = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (!out_valid) break;
            pops++;
        end
        chk("bp_drain_pops", 64'(pops), 64'd6);

        // Flush with 5 queued entries and a packet arriving the same cycle.
        cyc();
        out_ready = 1'b0;
        send(32'h1C000200, 64'h0000000B_0000000A, 7'd0);
        cyc();
        send(32'h1C000208, 64'h0000000D_0000000C, 7'd0);
        cyc();
        send(32'h1C000214, 64'h0000000F_0000000E, 7'd0);
        cyc();
        send(32'h1C000220, 64'h44444444_33333333, 7'd0);
        flush = 1'b1;
        cyc();
        flush = 1'b0;
        send(32'h1C000300, 64'h66666666_55555555, 7'd0);
        @(negedge clk);
        chk("fl_out_valid", 64'(out_valid), 64'd0);
        chk("fl_in_ready", 64'(in_ready), 64'd1);
        cyc();
        in_valid = 1'b0;
        @(negedge clk);
        chk("fl_next_pc", 64'(out_pc), 64'h1C000300);
        chk("fl_next_inst", 64'(out_inst), 64'h55555555);
        out_ready = 1'b1;
        cyc(); cyc();

        // Low PC bits pass through unchanged.
        send(32'h1C000402, 64'h88888888_77777777, 7'd0);
        cyc();
        in_valid = 1'b0;
        @(negedge clk);
        chk("lo_pc0", 64'(out_pc), 64'h1C000402);
        chk("lo_inst0", 64'(out_inst), 64'h77777777);
        cyc();
        @(negedge clk);
        chk("lo_pc1", 64'(out_pc), 64'h1C000406);
        cyc();
        @(negedge clk);
        chk("end_empty", 64'(out_valid), 64'd0);

        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
